// File: rtl/enet_mii_rx_deframe.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes,
// checks the CRC-32 FCS, and flags status and good/bad counts per frame.
//   clk, rst           : mii_rx_clk and synchronous active-high reset
//   mii_rx_dv/er/rxd   : MII receive nibble stream
//   rx_data/valid      : byte stream out, FCS included, one-byte hold delay
//   rx_sof/eof         : first/last byte markers, qualified by rx_valid
//   rx_status          : {phy_err, align_err, len_long, len_short, crc_err}
//   rx_good/bad_cnt    : wrapping frame counters
module enet_mii_rx_deframe #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mii_rx_dv,
  input  logic             mii_rx_er,
  input  logic [3:0]       mii_rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic [4:0]       rx_status,
  output logic [CNT_W-1:0] rx_good_cnt,
  output logic [CNT_W-1:0] rx_bad_cnt
);

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, PRE, DATA, DROP
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] len_q, len_d;
  logic        phy_q, phy_d;
  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
  logic        first_q, first_d;

  logic [7:0]       data_d;
  logic             valid_d, sof_d, eof_d;
  logic [4:0]       status_d;
  logic [CNT_W-1:0] good_d, bad_d;

  logic [7:0]  byte_w;
  logic [31:0] crc_w;
  logic [4:0]  status_w;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign byte_w   = {mii_rxd, low_q};
  assign crc_w    = crc_byte(crc_q, byte_w);
  assign status_w = {phy_q, phase_q, len_q > MAX_L,
                     len_q < MIN_L, crc_q != RESIDUE};

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    low_d    = low_q;
    crc_d    = crc_q;
    len_d    = len_q;
    phy_d    = phy_q;
    hold_d   = hold_q;
    full_d   = full_q;
    first_d  = first_q;
    data_d   = rx_data;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    status_d = 5'd0;
    good_d   = rx_good_cnt;
    bad_d    = rx_bad_cnt;
    unique case (state_q)
      WAIT_IDLE: begin
        if (!mii_rx_dv) state_d = IDLE;
      end
      IDLE: begin
        if (mii_rx_dv)
          state_d = (mii_rxd == 4'h5) ? PRE : DROP;
      end
      PRE: begin
        if (!mii_rx_dv) begin
          state_d = IDLE;
        end else if (mii_rxd == 4'hD) begin
          state_d = DATA;
          phase_d = 1'b0;
          len_d   = 11'd0;
          crc_d   = 32'hFFFFFFFF;
          phy_d   = 1'b0;
          full_d  = 1'b0;
        end else if (mii_rxd != 4'h5) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!mii_rx_dv) begin
          state_d = IDLE;
          full_d  = 1'b0;
          // zero completed bytes: frame vanishes silently
          if (full_q) begin
            valid_d  = 1'b1;
            eof_d    = 1'b1;
            sof_d    = first_q;
            data_d   = hold_q;
            status_d = status_w;
            if (status_w == 5'd0) good_d = rx_good_cnt + ONE;
            else                  bad_d  = rx_bad_cnt + ONE;
          end
        end else begin
          phy_d = phy_q | mii_rx_er;
          if (!phase_q) begin
            low_d   = mii_rxd;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_w;
            if (len_q != 11'h7FF) len_d = len_q + 11'd1;
            // hold register delays output so the last byte can carry eof
            if (full_q) begin
              valid_d = 1'b1;
              sof_d   = first_q;
              data_d  = hold_q;
            end
            hold_d  = byte_w;
            full_d  = 1'b1;
            first_d = !full_q;
          end
        end
      end
      DROP: begin
        if (!mii_rx_dv) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      phase_q     <= 1'b0;
      low_q       <= 4'd0;
      crc_q       <= 32'hFFFFFFFF;
      len_q       <= 11'd0;
      phy_q       <= 1'b0;
      hold_q      <= 8'd0;
      full_q      <= 1'b0;
      first_q     <= 1'b0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      rx_sof      <= 1'b0;
      rx_eof      <= 1'b0;
      rx_status   <= 5'd0;
      rx_good_cnt <= '0;
      rx_bad_cnt  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      low_q       <= low_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      phy_q       <= phy_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      first_q     <= first_d;
      rx_data     <= data_d;
      rx_valid    <= valid_d;
      rx_sof      <= sof_d;
      rx_eof      <= eof_d;
      rx_status   <= status_d;
      rx_good_cnt <= good_d;
      rx_bad_cnt  <= bad_d;
    end
  end

endmodule
